// File: rtl/vsync_pkg.sv
// Shared state encoding and default parameter values for the frame capture scheduler.
package vsync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam int DEF_NUM_FRAMES_W = 8;
  localparam bit DEF_VSYNC_POL    = 1'b1;
  localparam int DEF_TIMEOUT_CYC  = 2000000;

endpackage

// File: rtl/vsync_edge_det.sv
// vsync synchronizer (2 FF) plus history FF; flags the sampled transition into the active level.
module vsync_edge_det
  import vsync_pkg::*;
#(
  parameter bit VSYNC_POL = DEF_VSYNC_POL
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic boundary,
  output logic level
);

  // sync_q[0] = s1, sync_q[1] = s2, sync_q[2] = s3 (history)
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb sync_d = {sync_q[1:0], vsync};

  always_ff @(posedge clk) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign level    = (sync_q[1] == VSYNC_POL);
  assign boundary = level && (sync_q[2] != VSYNC_POL);

endmodule

// File: rtl/frame_capture_sched.sv
// Frame capture scheduler: captures a requested number of camera frames framed by vsync.
// Optional watchdog enabled with the VSYNC_TIMEOUT_EN macro.
//
// state        | meaning
// ST_IDLE      | waiting for start
// ST_WAIT_EDGE | capture armed, waiting for the first frame boundary
// ST_CAPTURE   | capture_en high, counting completed frames
// ST_DONE      | one-cycle completion, finished pulses on the way out
module frame_capture_sched
  import vsync_pkg::*;
#(
  parameter int NUM_FRAMES_W = DEF_NUM_FRAMES_W,
  parameter bit VSYNC_POL    = DEF_VSYNC_POL,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vsync,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_FRAMES_W-1:0] num_frames,
  output logic                    capture_en,
  output logic                    frame_start,
  output logic                    busy,
  output logic                    finished,
  output logic                    timeout_err
);

  logic boundary;
  logic vsync_level;

  vsync_edge_det #(.VSYNC_POL(VSYNC_POL)) u_edge_det (
    .clk      (clk),
    .reset    (reset),
    .vsync    (vsync),
    .boundary (boundary),
    .level    (vsync_level)
  );

  state_e                  state_q, state_d;
  logic [NUM_FRAMES_W-1:0] target_q, target_d;
  logic [NUM_FRAMES_W-1:0] count_q, count_d;
  logic                    cap_q, cap_d;
  logic                    fs_q, fs_d;
  logic                    busy_q, busy_d;
  logic                    fin_q, fin_d;

`ifdef VSYNC_TIMEOUT_EN
  localparam int            WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_INIT = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    count_d  = count_q;
    cap_d    = cap_q;
    fs_d     = 1'b0;
    fin_d    = 1'b0;
`ifdef VSYNC_TIMEOUT_EN
    wd_d     = wd_q;
    tmo_d    = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          count_d = '0;
          if (num_frames == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_WAIT_EDGE;
            target_d = num_frames;
          end
        end
      end
      ST_WAIT_EDGE: begin
        if (abort) begin
          state_d = ST_IDLE;
          cap_d   = 1'b0;
        end else if (boundary) begin
          state_d = ST_CAPTURE;
          cap_d   = 1'b1;
          fs_d    = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
          cap_d   = 1'b0;
        end else if (boundary) begin
          // count holds completed frames; compare before it could ever wrap
          count_d = count_q + NUM_FRAMES_W'(1);
          if (count_d == target_q) begin
            state_d = ST_DONE;
            cap_d   = 1'b0;
          end else begin
            fs_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        fin_d   = !abort;
      end
      default: begin
        state_d = ST_IDLE;
        cap_d   = 1'b0;
      end
    endcase
`ifdef VSYNC_TIMEOUT_EN
    if (state_q == ST_IDLE) begin
      if (start && !abort) begin
        tmo_d = 1'b0;
        wd_d  = WD_INIT;
      end
    end else if ((state_q == ST_WAIT_EDGE || state_q == ST_CAPTURE) && !abort) begin
      if (boundary) begin
        wd_d = WD_INIT;
      end else if (wd_q == '0) begin
        tmo_d   = 1'b1;
        state_d = ST_IDLE;
        cap_d   = 1'b0;
        fs_d    = 1'b0;
      end else begin
        wd_d = wd_q - WD_W'(1);
      end
    end
`endif
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      count_q  <= '0;
      cap_q    <= 1'b0;
      fs_q     <= 1'b0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
`ifdef VSYNC_TIMEOUT_EN
      wd_q     <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      cap_q    <= cap_d;
      fs_q     <= fs_d;
      busy_q   <= busy_d;
      fin_q    <= fin_d;
`ifdef VSYNC_TIMEOUT_EN
      wd_q     <= wd_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign capture_en  = cap_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign finished    = fin_q;
`ifdef VSYNC_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_capture_sched.sv
// Bench for frame_capture_sched: two instances (rising and falling vsync polarity) checked against
// an event-level model of boundary times, frame counts and pulse positions.
module tb_frame_capture_sched;

  localparam int TMO = 500;
`ifdef VSYNC_TIMEOUT_EN
  localparam int P_LONG = 450;
`else
  localparam int P_LONG = 1000;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vsync_a = 1'b0;
  logic       vsync_b = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] num_frames = 8'd0;
  logic       cap_a, fs_a, busy_a, fin_a, tmo_a;
  logic       cap_b, fs_b, busy_b, fin_b, tmo_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_capture_sched #(.NUM_FRAMES_W(8), .VSYNC_POL(1'b1), .TIMEOUT_CYC(TMO)) dut_a (
    .clk(clk), .reset(reset), .vsync(vsync_a), .start(start), .abort(abort),
    .num_frames(num_frames), .capture_en(cap_a), .frame_start(fs_a), .busy(busy_a),
    .finished(fin_a), .timeout_err(tmo_a)
  );

  frame_capture_sched #(.NUM_FRAMES_W(8), .VSYNC_POL(1'b0), .TIMEOUT_CYC(TMO)) dut_b (
    .clk(clk), .reset(reset), .vsync(vsync_b), .start(start), .abort(abort),
    .num_frames(num_frames), .capture_en(cap_b), .frame_start(fs_b), .busy(busy_b),
    .finished(fin_b), .timeout_err(tmo_b)
  );

  // Square-wave vsync: active for the first half of each period.
  function automatic bit wave(input int i, input int period, input int phase);
    return ((i + phase) % period) < (period / 2);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; reset = 1'b1;
      vsync_a = 1'b0; vsync_b = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset = 1'b0; start = 1'b1; num_frames = 8'd2;
      vsync_a = i[0]; vsync_b = ~i[0];
      @(posedge clk); #1;
      checks++;
      if ({cap_a, fs_a, busy_a, fin_a, tmo_a} !== 5'b0) begin
        errors++; $display("FAIL reset_a edge %0d: got %b want 00000", i, {cap_a, fs_a, busy_a, fin_a, tmo_a});
      end
      checks++;
      if ({cap_b, fs_b, busy_b, fin_b, tmo_b} !== 5'b0) begin
        errors++; $display("FAIL reset_b edge %0d: got %b want 00000", i, {cap_b, fs_b, busy_b, fin_b, tmo_b});
      end
    end
    idle(6);
  endtask

  // Capture of n frames; start sampled at edge 0. Each sampled vsync activation at edge k
  // is acted on at edge k+2. busy_start_at >= 0 issues an extra start (and num_frames is
  // scrambled) while busy, which must change nothing.
  task automatic test_capture(input string name, input int n, input int period, input int phase,
                              input int busy_start_at);
    int e_q[$];
    int last, fs_cnt, fin_cnt;
    logic [4:0] exp_v;
    logic exp_fs;
    for (int i = 0; e_q.size() < n + 1 && i < 60000; i++)
      if (wave(i, period, phase) && (i == 0 || !wave(i - 1, period, phase))) e_q.push_back(i + 2);
    last = e_q[n] + 4;
    fs_cnt = 0; fin_cnt = 0;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      start = (i == 0) || (i == busy_start_at);
      num_frames = (i == 0) ? 8'(n) : ~8'(n);
      vsync_a = wave(i, period, phase); vsync_b = ~vsync_a;
      @(posedge clk); #1;
      exp_fs = 1'b0;
      for (int j = 0; j < n; j++) if (i == e_q[j]) exp_fs = 1'b1;
      exp_v = {(i >= e_q[0]) && (i < e_q[n]), exp_fs, i <= e_q[n], i == e_q[n] + 1, 1'b0};
      checks++;
      if ({cap_a, fs_a, busy_a, fin_a, tmo_a} !== exp_v) begin
        errors++; $display("FAIL %s_a cycle %0d: got %b want %b (cap fs busy fin tmo)", name, i, {cap_a, fs_a, busy_a, fin_a, tmo_a}, exp_v);
      end
      checks++;
      if ({cap_b, fs_b, busy_b, fin_b, tmo_b} !== exp_v) begin
        errors++; $display("FAIL %s_b cycle %0d: got %b want %b (cap fs busy fin tmo)", name, i, {cap_b, fs_b, busy_b, fin_b, tmo_b}, exp_v);
      end
      fs_cnt += int'(fs_a); fin_cnt += int'(fin_a);
    end
    checks++;
    if (fs_cnt != n || fin_cnt != 1) begin
      errors++; $display("FAIL %s_pulse_count: got fs=%0d fin=%0d want fs=%0d fin=1", name, fs_cnt, fin_cnt, n);
    end
    idle(6);
  endtask

  task automatic test_zero_frames();
    logic [4:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = (i == 0); num_frames = 8'd0;
      @(posedge clk); #1;
      exp_v = {1'b0, 1'b0, i == 0, i == 1, 1'b0};
      checks++;
      if ({cap_a, fs_a, busy_a, fin_a, tmo_a} !== exp_v || {cap_b, fs_b, busy_b, fin_b, tmo_b} !== exp_v) begin
        errors++; $display("FAIL zero_frames cycle %0d: got a=%b b=%b want %b", i, {cap_a, fs_a, busy_a, fin_a, tmo_a}, {cap_b, fs_b, busy_b, fin_b, tmo_b}, exp_v);
      end
    end
    idle(4);
  endtask

  // kind 0: abort during frame 2; kind 1: reset low for one edge during frame 2.
  task automatic test_interrupt(input string name, input int kind);
    int e_q[$];
    int period, phase, n, cut_at;
    logic exp_fs;
    logic [4:0] exp_v;
    n = 4 + kind; period = 40; phase = int'($urandom_range(0, 39));
    for (int i = 0; e_q.size() < n + 1; i++)
      if (wave(i, period, phase) && (i == 0 || !wave(i - 1, period, phase))) e_q.push_back(i + 2);
    cut_at = e_q[1] + int'($urandom_range(1, period - 5));
    for (int i = 0; i <= cut_at + 2 * period; i++) begin
      @(negedge clk);
      start = (i == 0); num_frames = 8'(n);
      abort = (kind == 0) && (i == cut_at);
      reset = !((kind == 1) && (i == cut_at));
      vsync_a = wave(i, period, phase); vsync_b = ~vsync_a;
      @(posedge clk); #1;
      exp_fs = (i == e_q[0]) || (i == e_q[1]);
      if (i < cut_at) exp_v = {i >= e_q[0], exp_fs, 1'b1, 1'b0, 1'b0};
      else            exp_v = 5'b0;
      checks++;
      if ({cap_a, fs_a, busy_a, fin_a, tmo_a} !== exp_v || {cap_b, fs_b, busy_b, fin_b, tmo_b} !== exp_v) begin
        errors++; $display("FAIL %s cycle %0d: got a=%b b=%b want %b", name, i, {cap_a, fs_a, busy_a, fin_a, tmo_a}, {cap_b, fs_b, busy_b, fin_b, tmo_b}, exp_v);
      end
    end
    idle(6);
  endtask

  task automatic test_start_abort_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = (i == 0); abort = (i == 0); num_frames = 8'd3;
      @(posedge clk); #1;
      checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0 || fin_a !== 1'b0) begin
        errors++; $display("FAIL start_abort_idle cycle %0d: got busy=%b%b fin=%b want busy=00 fin=0", i, busy_a, busy_b, fin_a);
      end
    end
    idle(4);
  endtask

  task automatic test_timeout();
    for (int i = 0; i <= 505; i++) begin
      @(negedge clk);
      start = (i == 0); num_frames = 8'd2;
      @(posedge clk); #1;
`ifdef VSYNC_TIMEOUT_EN
      checks++;
      if (tmo_a !== (i >= TMO) || tmo_b !== (i >= TMO) || busy_a !== (i < TMO) || busy_b !== (i < TMO) || fin_a !== 1'b0) begin
        errors++; $display("FAIL timeout cycle %0d: got tmo=%b%b busy=%b%b fin=%b want tmo=%0d busy=%0d fin=0", i, tmo_a, tmo_b, busy_a, busy_b, fin_a, i >= TMO, i < TMO);
      end
`else
      checks++;
      if (tmo_a !== 1'b0 || tmo_b !== 1'b0 || busy_a !== 1'b1 || busy_b !== 1'b1) begin
        errors++; $display("FAIL no_watchdog cycle %0d: got tmo=%b%b busy=%b%b want tmo=00 busy=11", i, tmo_a, tmo_b, busy_a, busy_b);
      end
`endif
    end
`ifdef VSYNC_TIMEOUT_EN
    // start+abort is not an accepted start, so the flag must survive it
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tmo_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky: got tmo=%b busy=%b want tmo=1 busy=0", tmo_a, busy_a);
    end
    @(negedge clk); start = 1'b1; abort = 1'b0; num_frames = 8'd1;
    @(posedge clk); #1;
    checks++;
    if (tmo_a !== 1'b0 || tmo_b !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL timeout_clear: got tmo=%b%b busy=%b want tmo=00 busy=1", tmo_a, tmo_b, busy_a);
    end
`endif
    @(negedge clk); start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0 || tmo_a !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: got busy=%b%b tmo=%b want busy=00 tmo=0", busy_a, busy_b, tmo_a);
    end
    idle(4);
  endtask

  initial begin
    int n, p;
    test_reset();
    test_capture("three_frames", 3, P_LONG, int'($urandom_range(0, P_LONG - 1)), -1);
    for (int r = 0; r < 5; r++) begin
      n = int'($urandom_range(1, 6));
      p = int'($urandom_range(8, 60));
      test_capture("random", n, p, int'($urandom_range(0, p - 1)), -1);
    end
    test_zero_frames();
    test_interrupt("abort_frame2", 0);
    test_capture("after_abort", 2, 20, 3, -1);
    test_start_abort_idle();
    test_capture("busy_start", 3, 40, 7, 50);
    test_interrupt("reset_mid", 1);
    test_capture("after_reset", 1, 16, 11, -1);
    test_capture("max_frames", 255, 6, 0, -1);
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_time_limit: got no finish want finish before limit");
    $fatal(1, "time limit");
  end

endmodule
